// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control FSM and its datapath.
// Widths follow the controller parameters; state is a debug view of the FSM.
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 32
);
   logic [OPCODE_W-1:0] opcode;
   // mem_ready: sampled only in FETCH/MEMRD/MEMWR; a high value completes the
   // access held by the controller that cycle, low stretches it by one cycle.
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                mem_to_reg;
   logic                reg_dst;
   logic                reg_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic [1:0]          pc_source;
   logic [CNT_W-1:0]    retired;
   logic                illegal;
   logic [3:0]          state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, retired, illegal, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, retired, illegal, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory wait handshake and retire counter.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOP.
module multicycle_control_unit #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 32
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_control_unit_if.master bus
);
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_RTYPE_EX = 4'd6;
   localparam logic [3:0] S_RTYPE_WB = 4'd7;
   localparam logic [3:0] S_BEQ      = 4'd8;
   localparam logic [3:0] S_ADDI_EX  = 4'd9;
   localparam logic [3:0] S_ADDI_WB  = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_TRAP     = 4'd12;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

   logic [3:0]          state;
   logic [3:0]          state_next;
   logic [OPCODE_W-1:0] op_q;
   logic                retire;
   logic [CNT_W-1:0]    retired_q;

   always_comb begin
      state_next = state;
      retire     = 1'b0;
      case (state)
         S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            if (bus.opcode == OP_RTYPE)                          state_next = S_RTYPE_EX;
            else if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_next = S_MEMADR;
            else if (bus.opcode == OP_BEQ)                       state_next = S_BEQ;
            else if (bus.opcode == OP_ADDI)                      state_next = S_ADDI_EX;
            else if (bus.opcode == OP_J)                         state_next = S_JUMP;
            else begin
`ifdef ILLEGAL_TRAP_EN
               state_next = S_TRAP;
`else
               state_next = S_FETCH;
               retire     = 1'b1;
`endif
            end
         end
         // Only lw/sw reach MEMADR, so the latched opcode picks read vs write.
         S_MEMADR:   state_next = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    if (bus.mem_ready) state_next = S_MEMWB;
         S_MEMWB: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            if (bus.mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_RTYPE_EX: state_next = S_RTYPE_WB;
         S_ADDI_EX:  state_next = S_ADDI_WB;
         S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_JUMP: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_TRAP:     state_next = S_TRAP;
         default:    state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         op_q      <= '0;
         retired_q <= '0;
      end else begin
         state <= state_next;
         if (state == S_DECODE) op_q <= bus.opcode;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = ALU_ADD;
      bus.pc_source     = 2'b00;
      case (state)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            // No PC/IR load while reset is held, even though FETCH is showing.
            if (bus.mem_ready && !reset) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
            end
         end
         S_DECODE:   bus.alu_src_b = 2'b11;
         S_MEMADR, S_ADDI_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         S_RTYPE_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_FUNCT;
         end
         S_RTYPE_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALU_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
         end
         S_ADDI_WB:  bus.reg_write = 1'b1;
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
         default: ;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal = (state == S_TRAP);
`else
   assign bus.illegal = 1'b0;
`endif
   assign bus.retired = retired_q;
   assign bus.state   = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected control-word
// sequences built from the instruction timing table, compared every cycle.
module tb_multicycle_control_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) bus ();
   multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Word order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], illegal
   logic [16:0] obs_word;
   assign obs_word = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.pc_source, bus.illegal};

   localparam logic [16:0] W_FETCH_STALL = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_FETCH_GO    = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_DECODE      = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_MEMADR      = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_MEMRD       = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_MEMWB       = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_MEMWR       = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_RTYPE_EX    = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [16:0] W_RTYPE_WB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_BEQ         = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
   localparam logic [16:0] W_ADDI_EX     = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_ADDI_WB     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] W_JUMP        = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
   localparam logic [16:0] W_TRAP        = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic [16:0] exp_q[$];
   logic [5:0]  op_q[$];
   logic        mr_q[$];
   logic [31:0] ret_q[$];
   logic [31:0] model_cnt;
   int          total = 0;
   int          bad   = 0;
   int          step  = 0;

   function automatic logic [5:0] rnd_op();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [5:0] op, input logic mr, input logic [16:0] w);
      op_q.push_back(op);
      mr_q.push_back(mr);
      exp_q.push_back(w);
      ret_q.push_back(model_cnt);
   endtask

   // Expected per-cycle words for one instruction; fs/ms = low mem_ready cycles
   // in fetch and in the data memory access. The opcode is scrambled outside
   // DECODE, so the design must hold its own copy.
   task automatic gen_instr(input logic [5:0] op, input int fs, input int ms);
      repeat (fs) push(rnd_op(), 1'b0, W_FETCH_STALL);
      push(rnd_op(), 1'b1, W_FETCH_GO);
      push(op, rnd_bit(), W_DECODE);
      case (op)
         OP_LW: begin
            push(rnd_op(), rnd_bit(), W_MEMADR);
            repeat (ms) push(rnd_op(), 1'b0, W_MEMRD);
            push(rnd_op(), 1'b1, W_MEMRD);
            push(rnd_op(), rnd_bit(), W_MEMWB);
            model_cnt++;
         end
         OP_SW: begin
            push(rnd_op(), rnd_bit(), W_MEMADR);
            repeat (ms) push(rnd_op(), 1'b0, W_MEMWR);
            push(rnd_op(), 1'b1, W_MEMWR);
            model_cnt++;
         end
         OP_R: begin
            push(rnd_op(), rnd_bit(), W_RTYPE_EX);
            push(rnd_op(), rnd_bit(), W_RTYPE_WB);
            model_cnt++;
         end
         OP_ADDI: begin
            push(rnd_op(), rnd_bit(), W_ADDI_EX);
            push(rnd_op(), rnd_bit(), W_ADDI_WB);
            model_cnt++;
         end
         OP_BEQ: begin
            push(rnd_op(), rnd_bit(), W_BEQ);
            model_cnt++;
         end
         OP_J: begin
            push(rnd_op(), rnd_bit(), W_JUMP);
            model_cnt++;
         end
         default: begin
`ifdef ILLEGAL_TRAP_EN
            repeat (6) push(rnd_op(), rnd_bit(), W_TRAP);
`else
            model_cnt++;
`endif
         end
      endcase
   endtask

   // Called at a falling edge; leaves at the next falling edge.
   task automatic drive_step(input logic [5:0] op, input logic mr,
                             input logic [16:0] w, input logic [31:0] r);
      bus.opcode    = op;
      bus.mem_ready = mr;
      #1;
      chk($sformatf("ctrl_c%0d", step), {15'b0, obs_word}, {15'b0, w});
      chk($sformatf("retired_c%0d", step), bus.retired, r);
      step++;
      @(negedge clk);
   endtask

   task automatic run_queue();
      while (exp_q.size() > 0)
         drive_step(op_q.pop_front(), mr_q.pop_front(), exp_q.pop_front(), ret_q.pop_front());
   endtask

   initial begin
      logic [5:0] legal [6];
      legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
      model_cnt     = '0;
      reset         = 1'b1;
      bus.opcode    = '0;
      bus.mem_ready = 1'b1;

      // Reset held two cycles with mem_ready high: only the fetch request shows.
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_ctrl", {15'b0, obs_word}, {15'b0, W_FETCH_STALL});
      chk("reset_retired", bus.retired, 32'd0);
      reset = 1'b0;

      gen_instr(OP_LW, 0, 0);
      gen_instr(OP_SW, 0, 3);
      gen_instr(OP_R, 0, 0);
      gen_instr(OP_ADDI, 0, 0);
      gen_instr(OP_BEQ, 0, 0);
      gen_instr(OP_J, 0, 0);
      run_queue();
      chk("retired_directed", bus.retired, 32'd6);

      for (int i = 0; i < 40; i++)
         gen_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3));
      run_queue();

      // Reset while a lw is stalled in its memory read.
      push(rnd_op(), 1'b1, W_FETCH_GO);
      push(OP_LW, rnd_bit(), W_DECODE);
      push(rnd_op(), rnd_bit(), W_MEMADR);
      push(rnd_op(), 1'b0, W_MEMRD);
      run_queue();
      reset = 1'b1;
      drive_step(rnd_op(), 1'b0, W_MEMRD, model_cnt);
      reset     = 1'b0;
      model_cnt = '0;
      gen_instr(OP_LW, 1, 1);
      run_queue();

      // Unknown opcode: trap or NOP depending on build.
      gen_instr(OP_BAD, 0, 0);
      run_queue();
`ifdef ILLEGAL_TRAP_EN
      chk("trap_retired_held", bus.retired, 32'd1);
      reset = 1'b1;
      drive_step(rnd_op(), 1'b1, W_TRAP, model_cnt);
      reset     = 1'b0;
      model_cnt = '0;
`else
      chk("nop_retired", bus.retired, 32'd2);
`endif
      gen_instr(OP_R, 0, 0);
      run_queue();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
